// File: rtl/switch_debounce_pio.sv
// Avalon-MM switch input peripheral: per-bit synchronizer, tick-based debouncer,
// edge capture with W1C clear, and a maskable level interrupt.
module switch_debounce_pio #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned TICK_DIV       = 50000,
   parameter int unsigned STABLE_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] sw_in
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = 4;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_RAW  = 2'd3;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [PW-1:0]    presc;
   logic             tick;
   logic [WIDTH-1:0] deb;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_clr;
   logic             unused_wdata;

   // Upper write-data bits are architecturally ignored when WIDTH < 32.
   assign unused_wdata = ^avs_writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
      end
   end

   assign tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // A bit flips once it has disagreed with deb for STABLE_SAMPLES consecutive ticks.
   always_comb begin
      toggle = '0;
      for (int i = 0; i < WIDTH; i++) begin
         toggle[i] = tick && (sync2[i] != deb[i]) &&
                     (cnt[i] == CW'(STABLE_SAMPLES - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         deb <= deb ^ toggle;
         for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
               if ((sync2[i] == deb[i]) || toggle[i]) begin
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end
         end
      end
   end

   assign edge_clr = (avs_write && (avs_address == ADDR_EDGE)) ?
                     avs_writedata[WIDTH-1:0] : '0;

   // A new edge in the same cycle as its W1C clear keeps the bit set.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cap <= '0;
         mask     <= '0;
      end else begin
         edge_cap <= (edge_cap & ~edge_clr) | toggle;
         if (avs_write && (avs_address == ADDR_MASK)) begin
            mask <= avs_writedata[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         case (avs_address)
            ADDR_DATA: avs_readdata <= 32'(deb);
            ADDR_MASK: avs_readdata <= 32'(mask);
            ADDR_EDGE: avs_readdata <= 32'(edge_cap);
            ADDR_RAW:  avs_readdata <= 32'(sync2);
         endcase
      end
   end

   assign irq = |(edge_cap & mask);

endmodule

// File: tb/tb_switch_debounce_pio.sv
// Directed bench for switch_debounce_pio with TICK_DIV=4, STABLE_SAMPLES=3, WIDTH=16.
module tb_switch_debounce_pio;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avs_address = 2'd0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic [31:0] avs_readdata;
   logic        irq;
   logic [15:0] sw_in = 16'h0000;

   int tests = 0;
   int fails = 0;
   int mp = 0;

   switch_debounce_pio #(
      .WIDTH(16),
      .TICK_DIV(4),
      .STABLE_SAMPLES(3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .sw_in         (sw_in)
   );

   always #5 clk = ~clk;

   // Expected prescaler phase, counting 0..3 from reset.
   always @(posedge clk) begin
      if (reset) mp <= 0;
      else       mp <= (mp == 3) ? 0 : mp + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      sw_in = 16'h0000;
      repeat (2) @(negedge clk);
      tests++;
      if (avs_readdata !== 32'h0) begin
         fails++; $display("FAIL reset_readdata: got %h expected %h", avs_readdata, 32'h0);
      end
      tests++;
      if (irq !== 1'b0) begin
         fails++; $display("FAIL reset_irq: got %b expected 0", irq);
      end
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         do_read(2'(a), d);
         tests++;
         if (d !== 32'h0) begin
            fails++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0);
         end
      end
   endtask

   task automatic test_clean_change();
      logic [31:0] d;
      int first;
      sw_in       = 16'h0005;
      avs_address = 2'd3;
      avs_read    = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (avs_readdata !== 32'h0) begin
         fails++; $display("FAIL raw_early: got %h expected %h", avs_readdata, 32'h0);
      end
      @(negedge clk);
      tests++;
      if (avs_readdata !== 32'h5) begin
         fails++; $display("FAIL raw_value: got %h expected %h", avs_readdata, 32'h5);
      end
      avs_address = 2'd0;
      first = 0;
      for (int n = 4; n <= 20; n++) begin
         @(negedge clk);
         if (first == 0 && avs_readdata === 32'h5) first = n;
      end
      avs_read = 1'b0;
      tests++;
      if (first < 12 || first > 15) begin
         fails++; $display("FAIL clean_latency: got cycle %0d expected 12..15", first);
      end
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h5) begin
         fails++; $display("FAIL clean_edge: got %h expected %h", d, 32'h5);
      end
      tests++;
      if (irq !== 1'b0) begin
         fails++; $display("FAIL clean_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      logic bad;
      bad         = 1'b0;
      sw_in       = 16'h000D;
      avs_address = 2'd0;
      avs_read    = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (n == 6) sw_in = 16'h0005;
         if (avs_readdata[3] !== 1'b0) bad = 1'b1;
      end
      avs_read = 1'b0;
      tests++;
      if (bad !== 1'b0 || avs_readdata !== 32'h5) begin
         fails++; $display("FAIL glitch_data: got %h (bit3 seen %b) expected %h", avs_readdata, bad, 32'h5);
      end
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h5) begin
         fails++; $display("FAIL glitch_edge: got %h expected %h", d, 32'h5);
      end
   endtask

   task automatic test_irq_mask();
      logic [31:0] d;
      do_read(2'd1, d);
      tests++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL irq_masked: got mask %h irq %b expected 0 and 0", d, irq);
      end
      do_write(2'd1, 32'h1);
      tests++;
      if (irq !== 1'b1) begin
         fails++; $display("FAIL irq_unmask: got %b expected 1", irq);
      end
      do_write(2'd2, 32'h1);
      tests++;
      if (irq !== 1'b0) begin
         fails++; $display("FAIL irq_clear: got %b expected 0", irq);
      end
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h4) begin
         fails++; $display("FAIL irq_edge_after_clear: got %h expected %h", d, 32'h4);
      end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] d;
      do_write(2'd2, 32'hFFFF);
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h0) begin
         fails++; $display("FAIL w1c_all: got %h expected %h", d, 32'h0);
      end
      for (int k = 0; k < 8 && mp != 3; k++) @(negedge clk);
      // Next edge is a tick; bit 2 falls, toggles on the third tick 12 edges later.
      sw_in = 16'h0001;
      repeat (12) @(negedge clk);
      do_write(2'd2, 32'h4);
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h4) begin
         fails++; $display("FAIL w1c_collision: got %h expected %h", d, 32'h4);
      end
      do_read(2'd0, d);
      tests++;
      if (d !== 32'h1) begin
         fails++; $display("FAIL w1c_data: got %h expected %h", d, 32'h1);
      end
      do_write(2'd2, 32'h0);
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h4) begin
         fails++; $display("FAIL w1c_zero: got %h expected %h", d, 32'h4);
      end
      do_write(2'd2, 32'h4);
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h0) begin
         fails++; $display("FAIL w1c_clear: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int first;
      sw_in = 16'hFFFF;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL mid_reset_out: got %h irq %b expected 0 and 0", avs_readdata, irq);
      end
      reset       = 1'b0;
      avs_address = 2'd0;
      avs_read    = 1'b1;
      first       = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin
            tests++;
            if (avs_readdata !== 32'h0) begin
               fails++; $display("FAIL mid_data_zero: got %h expected %h", avs_readdata, 32'h0);
            end
         end
         if (first == 0 && avs_readdata === 32'hFFFF) first = n;
      end
      avs_read = 1'b0;
      tests++;
      if (first != 13) begin
         fails++; $display("FAIL mid_latency: got cycle %0d expected 13", first);
      end
      do_read(2'd2, d);
      tests++;
      if (d !== 32'hFFFF) begin
         fails++; $display("FAIL mid_edge: got %h expected %h", d, 32'hFFFF);
      end
      do_read(2'd1, d);
      tests++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL mid_mask: got %h irq %b expected 0 and 0", d, irq);
      end
   endtask

   task automatic test_upper_bits();
      logic [31:0] d;
      do_write(2'd1, 32'hFFFF_FFFF);
      do_read(2'd1, d);
      tests++;
      if (d !== 32'h0000_FFFF) begin
         fails++; $display("FAIL mask_width: got %h expected %h", d, 32'h0000_FFFF);
      end
      tests++;
      if (irq !== 1'b1) begin
         fails++; $display("FAIL mask_all_irq: got %b expected 1", irq);
      end
      do_write(2'd0, 32'h0);
      do_read(2'd0, d);
      tests++;
      if (d !== 32'hFFFF) begin
         fails++; $display("FAIL data_ro: got %h expected %h", d, 32'hFFFF);
      end
      do_write(2'd2, 32'hFFFF_FFFF);
      do_read(2'd2, d);
      tests++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL edge_all_clear: got %h irq %b expected 0 and 0", d, irq);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_clean_change();
      test_glitch();
      test_irq_mask();
      test_w1c_collision();
      test_reset_mid();
      test_upper_bits();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/switch_debounce_pio.md
# switch_debounce_pio

Avalon-MM slave peripheral that conditions the board slide switches before the Nios II processor reads them. Each switch bit passes through a two-flop synchronizer and a tick-based debouncer. The block also provides a readable debounced value, a per-bit edge-capture register, and a maskable interrupt. It sits between the top-level `SW` pins and the Nios system bus, in place of a plain input PIO.

## Interface

Parameters:
- `WIDTH`, 16: number of switch inputs, 1..32.
- `TICK_DIV`, 50000: clock cycles per debounce sample tick (1 ms at 50 MHz), ≥2.
- `STABLE_SAMPLES`, 4: consecutive differing ticks needed to accept a change, 1..15.

Ports:
- `clk`  in  1  system clock, the `clk_clk` domain.
- `reset`  in  1  synchronous, active-high reset.
- `avs_address`  in  2  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, fixed read latency 1.
- `irq`  out  1  level interrupt, active high.
- `sw_in`  in  WIDTH  raw asynchronous switch pins (conduit).

## Operation

Register map. Bits above WIDTH read as 0.
- 0 DATA (RO): debounced switch value.
- 1 IRQMASK (RW): per-bit interrupt enable.
- 2 EDGE (R/W1C): per-bit edge capture. Writing 1 clears the bit; writing 0 has no effect.
- 3 RAW (RO): synchronized, undebounced input.
- Writes to addresses 0 and 3 are ignored.

Datapath:
- Synchronizer: two flops per bit, `sync2 <= sync1 <= sw_in`.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when count == TICK_DIV-1.
- Per-bit debouncer: `deb[i]` is the debounced value and `cnt[i]` is a 4-bit counter. Updates happen only on `tick`:
  - `sync2[i] == deb[i]`: `cnt[i] <= 0`.
  - `sync2[i] != deb[i]` and `cnt[i] == STABLE_SAMPLES-1`: `deb[i]` toggles and `cnt[i] <= 0`.
  - Otherwise: `cnt[i]` increments.
- A glitch that lasts fewer than STABLE_SAMPLES ticks never changes `deb`.

Edge capture:
- `edge[i]` sets on the clock edge where `deb[i]` toggles, for both rising and falling transitions.
- `edge[i]` stays set until cleared by a W1C write.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- `irq = |(edge & mask)`, driven from registered state only, no combinational path from the bus.

## Timing

Reset:
- All flops clear in the cycle `reset` is sampled high: `sync1`, `sync2`, prescaler, `deb`, all `cnt`, `mask`, `edge`, `avs_readdata` all go to 0.
- `irq` is therefore 0 out of reset.
- A switch held high through reset produces a rising edge once debounced.
- Reset asserted mid-debounce discards partial counts.

Reads:
- `avs_readdata` is registered and valid the cycle after `avs_read` is sampled. Between reads it holds its last value.
- A read of EDGE in the same cycle as a W1C write returns the pre-write value.

Writes:
- Take effect on the clock edge where `avs_write` is sampled.
- A mask write changes `irq` the following cycle.

Latency:
- `sw_in` to `sync2`: 2 cycles.
- `sync2` change to `deb` change: at most STABLE_SAMPLES ticks.
- Worst case from `sw_in` to `deb`: 2 + STABLE_SAMPLES×TICK_DIV cycles.
- `edge` updates in the same cycle as `deb`; `irq` follows with no further delay.

Other:
- No wait-request is generated; every access completes.

## Test plan

All scenarios use TICK_DIV=4, STABLE_SAMPLES=3, WIDTH=16.

- **Reset defaults:** hold `reset` 2 cycles with `sw_in`=0, then read addresses 0..3 → all return 0x00000000, `irq`=0.
- **Clean change:** set `sw_in`=0x0005 and hold → RAW reads 0x0005 after 3 cycles; DATA reads 0x0005 no later than 2+12 cycles; EDGE reads 0x0005.
- **Glitch rejection:** pulse `sw_in[3]`=1 for 6 cycles, then back to 0 → DATA bit 3 stays 0 and EDGE bit 3 stays 0 throughout.
- **Interrupt masking:** debounce bit 0 high with IRQMASK=0 → `irq`=0. Write IRQMASK=0x0001 → `irq`=1 the next cycle. Write EDGE=0x0001 → `irq`=0.
- **W1C collision:** time a W1C of bit 2 into the same cycle `deb[2]` toggles → EDGE bit 2 remains 1. Write 0x0000 to EDGE → no bits change.
- **Reset mid-debounce:** set `sw_in`=0xFFFF, assert `reset` after 2 ticks, release → DATA reads 0 right after reset, then 0xFFFF after a full fresh debounce interval. EDGE=0xFFFF at that point.
